// File: rtl/decoder_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_stream_pkg
// Description : Mode encodings and the shared index-to-pattern decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_stream_pkg;

    localparam logic [1:0] MODE_OH_LOW  = 2'd0;
    localparam logic [1:0] MODE_OH_HIGH = 2'd1;
    localparam logic [1:0] MODE_THERM   = 2'd2;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    // Produces the widest pattern; callers keep the low 2**SEL_W bits,
    // which are identical for any narrower SEL_W.
    function automatic logic [MAX_OUT_W-1:0] decode_pattern(
        input logic [MAX_SEL_W-1:0] idx,
        input logic [1:0]           mode,
        input logic                 oor
    );
        logic [MAX_OUT_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            case (mode)
                MODE_OH_HIGH: pat[i] = !oor && (i == int'(idx));
                MODE_THERM:   pat[i] = !oor && (i <= int'(idx));
                default:      pat[i] = oor || (i != int'(idx));
            endcase
        end
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_skid.sv
`default_nettype none
// ============================================================================
// Module      : decoder_skid
// Description : Valid/ready output register backed by a one-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_skid #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         skid_full
);

    logic [W-1:0] skid_data;
    logic         load_out;

    assign load_out = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (load_out) begin
            if (skid_full) begin
                // Older skid word goes first; a simultaneous push refills the skid.
                out_data  <= skid_data;
                out_valid <= 1'b1;
                skid_full <= push;
                if (push) begin
                    skid_data <= push_data;
                end
            end else if (push) begin
                out_data  <= push_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (push) begin
            skid_data <= push_data;
            skid_full <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : decoder_stream
// Description : Flow-controlled SEL_W-to-2**SEL_W decoder with range check,
//               saturating error counter and skid-buffered output.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_stream
    import decoder_stream_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int SEL_W = 3,
    parameter int ERR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       in_data,
    input  logic [1:0]            in_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [(1<<SEL_W)-1:0] out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  err_clr,
    output logic [ERR_W-1:0]      err_cnt
);

    localparam int OUT_W = 1 << SEL_W;

    logic             enable;
    logic             skid_full;
    logic             accept;
    logic             oor;
    logic [OUT_W-1:0] pattern;
    logic [OUT_W:0]   stage_out;

    assign oor      = |in_data[IN_W-1:SEL_W];
    assign pattern  = OUT_W'(decode_pattern(MAX_SEL_W'(in_data[SEL_W-1:0]), in_mode, oor));
    assign in_ready = enable && !skid_full;
    assign accept   = in_valid && in_ready;

    // Holds off acceptance for one cycle after every reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable <= 1'b0;
        end else begin
            enable <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= ERR_W'(accept && oor);
        end else if (accept && oor && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

    decoder_skid #(
        .W (OUT_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data ({oor, pattern}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (stage_out),
        .skid_full (skid_full)
    );

    assign out_err  = stage_out[OUT_W];
    assign out_data = stage_out[OUT_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_decoder_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_stream
// Description : Directed and randomized checks of decoder_stream against a
//               word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        err_clr;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    decoder_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    // Reference model: words held inside the block, in delivery order.
    logic [8:0]  q[$];
    bit          en_m;
    logic [15:0] err_m;
    int          n_checks;
    int          n_pass;
    logic [7:0]  got_seq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ref_word(input logic [31:0] d, input logic [1:0] m);
        int k;
        int p;
        bit bad;
        k   = int'(d[2:0]);
        bad = (d >= 32'd8);
        if (bad)                p = (m == 2'd1 || m == 2'd2) ? 0 : 255;
        else if (m == 2'd1)     p = 1 << k;
        else if (m == 2'd2)     p = (1 << (k + 1)) - 1;
        else                    p = 255 - (1 << k);
        return {bad, p[7:0]};
    endfunction

    task automatic model_edge();
        bit acc;
        bit bad;
        if (rst) begin
            q.delete();
            en_m  = 0;
            err_m = '0;
        end else begin
            acc = in_valid && en_m && (q.size() < 2);
            bad = acc && (in_data >= 32'd8);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(ref_word(in_data, in_mode));
            if (err_clr)                         err_m = bad ? 16'd1 : 16'd0;
            else if (bad && err_m != 16'hFFFF)   err_m = err_m + 16'd1;
            en_m = 1;
        end
    endtask

    task automatic check_outputs();
        check("in_ready", in_ready, en_m && (q.size() < 2));
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0][7:0]);
            check("out_err", out_err, q[0][8]);
        end
        check("err_cnt", err_cnt, err_m);
    endtask

    // Inputs are set before the call; one clock edge is applied, then outputs checked.
    task automatic tick();
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic bit model_accepts();
        return in_valid && !rst && en_m && (q.size() < 2);
    endfunction

    logic [7:0] t2_exp [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        en_m     = 0;
        err_m    = '0;
        t2_exp   = '{8'hDF, 8'h20, 8'h3F, 8'hDF};

        // Warm-up
        rst = 1; in_valid = 1; in_data = 0; in_mode = 0; out_ready = 1; err_clr = 0;
        repeat (3) tick();
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_err", err_cnt, 0);
        rst = 0;
        check("t1_rdy_first", in_ready, 0);
        tick();
        check("t1_rdy_next", in_ready, 1);
        tick();
        check("t1_data", out_data, 8'hFE);
        in_valid = 0;
        repeat (2) tick();

        // All modes for k = 5
        for (int m = 0; m < 4; m++) begin
            in_valid = 1; in_data = 5; in_mode = 2'(m);
            tick();
            check("t2_mode", out_data, t2_exp[m]);
            check("t2_err", out_err, 0);
        end
        in_valid = 0;
        tick();

        // Out of range
        in_valid = 1; in_data = 32'h8; in_mode = 0;
        tick();
        check("t3_data0", out_data, 8'hFF);
        check("t3_err0", out_err, 1);
        in_data = 32'h8000_0001; in_mode = 1;
        tick();
        check("t3_data1", out_data, 8'h00);
        check("t3_err1", out_err, 1);
        in_valid = 0;
        tick();
        check("t3_cnt", err_cnt, 2);

        // Back-pressure
        begin
            int sent;
            bit acc;
            sent = 0;
            got_seq.delete();
            in_mode = 1;
            for (int c = 0; c < 40; c++) begin
                in_valid  = (sent < 8);
                in_data   = sent;
                out_ready = !(c >= 3 && c < 7);
                if (out_valid && out_ready) got_seq.push_back(out_data);
                acc = model_accepts();
                tick();
                if (acc) sent++;
                if (c == 6) check("t4_rdy_stall", in_ready, 0);
            end
            in_valid  = 0;
            out_ready = 1;
            check("t4_count", got_seq.size(), 8);
            for (int j = 0; j < got_seq.size(); j++) begin
                check("t4_order", got_seq[j], 32'd1 << j);
            end
        end

        // Counter saturation and clear
        err_clr = 1; in_valid = 0;
        tick();
        check("t5_clr0", err_cnt, 0);
        err_clr = 0; in_valid = 1; in_data = 32'h100; out_ready = 1;
        repeat (65535) begin
            in_mode = 2'($urandom_range(0, 3));
            tick();
        end
        check("t5_sat", err_cnt, 16'hFFFF);
        repeat (3) tick();
        check("t5_hold", err_cnt, 16'hFFFF);
        err_clr = 1;
        tick();
        check("t5_clr_inc", err_cnt, 1);
        in_valid = 0;
        tick();
        check("t5_clr_only", err_cnt, 0);
        err_clr = 0;

        // Reset with both stages full
        in_valid = 1; in_data = 32'h40; in_mode = 1; out_ready = 0;
        repeat (3) tick();
        check("t6_full", in_ready, 0);
        rst = 1;
        tick();
        check("t6_valid", out_valid, 0);
        check("t6_cnt", err_cnt, 0);
        check("t6_rdy", in_ready, 0);
        rst = 0; in_data = 3; in_mode = 2; out_ready = 1;
        tick();
        tick();
        check("t6_data", out_data, 8'h0F);
        in_valid = 0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            err_clr   = ($urandom_range(0, 29) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_mode   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) in_data = $urandom | 32'h8;
            else                           in_data = $urandom_range(0, 7);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
Parametrised, flow-controlled successor to the fixed 3-to-8 decoder. It decodes the low SEL_W bits of an IN_W-bit word into a 2**SEL_W-bit pattern. Three output modes are selectable per transaction. Out-of-range inputs are flagged and counted, and the result leaves through a valid/ready output stage with a skid buffer. It sits between a valid/ready producer and consumer in the datapath test designs and replaces free-running decoders that have no back-pressure.

Parameters:
IN_W, 32, input word width; must be greater than SEL_W.
SEL_W, 3, decoded index width; OUT_W = 2**SEL_W is a localparam (default 8).
ERR_W, 16, width of the saturating out-of-range counter.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_data  input  IN_W  word to decode
in_mode  input  2  0 = one-hot active-low, 1 = one-hot active-high, 2 = thermometer, 3 = reserved (treated as 0)
in_valid  input  1  input word present
in_ready  output  1  block can accept a word this cycle
out_data  output  OUT_W  decoded pattern
out_err  output  1  word was out of range (bits above SEL_W nonzero)
out_valid  output  1  out_data/out_err valid
out_ready  input  1  consumer accepts this cycle
err_clr  input  1  synchronous clear of err_cnt
err_cnt  output  ERR_W  saturating count of accepted out-of-range words

Behaviour:
- Reset values:
  - out_data = 0, out_err = 0, out_valid = 0, in_ready = 0, err_cnt = 0.
  - Internal enable = 0 and skid_valid = 0.
- Warm-up:
  - enable is registered and becomes 1 on the first clock after rst deasserts.
  - in_ready = enable & !skid_valid.
  - No word is accepted while enable = 0.
- Accept condition: in_valid & in_ready. Words presented without acceptance are ignored.
- Decode of index k = in_data[SEL_W-1:0]:
  - mode 0: all ones except bit k = 0.
  - mode 1: only bit k = 1.
  - mode 2: bits [k:0] = 1, higher bits = 0.
- Out of range (in_data[IN_W-1:SEL_W] != 0):
  - out_err = 1.
  - Pattern is the inactive value: all ones in mode 0/3, all zeros in mode 1/2.
- Latency: an accepted word appears on out_data/out_valid on the next clock when the output stage is free.
- Output stage (register plus one-entry skid):
  - Output register loads when empty, or when out_ready is high that cycle.
  - On an accept while out_valid & !out_ready, the word goes to the skid register and skid_valid = 1. in_ready therefore drops on the next cycle.
  - When out_ready & skid_valid, the skid moves into the output register and skid_valid = 0 unless a new word is accepted into the skid that same cycle. That cannot happen, because in_ready = 0 while skid_valid = 1.
  - out_valid falls only on out_ready with both stages empty of new data.
  - out_data/out_err hold stable while out_valid & !out_ready.
- Ordering: strictly FIFO. No word is dropped or duplicated.
- err_cnt:
  - Increments by 1 on each accepted out-of-range word.
  - Saturates at all ones.
  - If err_clr and an increment occur in the same cycle, the result is 1.
  - err_clr alone gives 0.
- Reset mid-operation: both stages are flushed, err_cnt is cleared, enable returns to 0, and warm-up is repeated. Pending words are discarded.

Decomposition:
- Package decoder_stream_pkg:
  - mode encodings MODE_OH_LOW = 2'd0, MODE_OH_HIGH = 2'd1, MODE_THERM = 2'd2.
  - A function decode_pattern(idx, mode, oor) returning OUT_W bits, parametrised via SEL_W.
- Sub-module decoder_skid: a generic valid/ready output register plus skid, with data width OUT_W+1. The decode logic stays combinational in the top module.

Test Plan:
(Default parameters throughout.)
1. Warm-up: rst high 3 cycles, then low; in_valid = 1 with data 0, mode 0 -> in_ready is 0 on the first cycle after reset and 1 on the next; accepted word produces out_data = 8'hFE one clock later.
2. Modes: k = 5 in modes 0, 1, 2, 3 back-to-back with out_ready = 1 -> out_data = 8'hDF, 8'h20, 8'h3F, 8'hDF on consecutive cycles, out_err = 0.
3. Out of range: in_data = 32'h8 in mode 0 then 32'h8000_0001 in mode 1 -> out_data = 8'hFF then 8'h00, out_err = 1 both times, err_cnt = 2.
4. Back-pressure: stream indices 0..7 in mode 1, out_ready low for 4 cycles mid-stream -> in_ready drops after one skid fill, out_data held stable, all eight one-hot values delivered in order with none lost.
5. Counter: force err_cnt to all ones via 65535 out-of-range words -> holds 16'hFFFF on further errors; err_clr together with an error gives 1; err_clr alone gives 0.
6. Reset mid-stream: rst asserted with both stages full -> next cycle out_valid = 0, err_cnt = 0, in_ready = 0; after warm-up the first new word is delivered correctly.
